// File: rtl/vec_alu_ctrl_pkg.sv
// Shared codes and types for the vector ALU controller and its field decoder.
// Optional vfmadd support is enabled by defining VEC_ALU_CTRL_FMADD_EN.
package vec_alu_ctrl_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;
  localparam logic [2:0] ALU_SRL = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b111;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_EQ   = 2'b01;
  localparam logic [1:0] BR_LT   = 2'b10;
  localparam logic [1:0] BR_GE   = 2'b11;

  localparam logic [1:0] DSP_ADD = 2'b00;
  localparam logic [1:0] DSP_MUL = 2'b01;
  localparam logic [1:0] DSP_SUB = 2'b11;

  localparam logic [2:0] F3_VADD   = 3'b000;
  localparam logic [2:0] F3_VSUB   = 3'b000;
  localparam logic [2:0] F3_VMUL   = 3'b001;
  localparam logic [2:0] F3_VFMADD = 3'b011;

  localparam logic [6:0] F7_VADD   = 7'b0000000;
  localparam logic [6:0] F7_VSUB   = 7'b0000100;
  localparam logic [6:0] F7_VMUL   = 7'b1000000;
  localparam logic [6:0] F7_VFMADD = 7'b1000011;

  typedef enum logic [1:0] {
    IDLE,
    SCALAR,
`ifdef VEC_ALU_CTRL_FMADD_EN
    VEC,
    VEC_ACC
`else
    VEC
`endif
  } state_t;

  // funct3 to ALU control for register/immediate arithmetic
  function automatic logic [2:0] f3_to_alu(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SUB;
      3'b011:  return ALU_SLT;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/vec_alu_ctrl_field_decode.sv
// Pure combinational decode of alu_op/funct3/funct7 into scalar and vector controls.
// vfmadd is recognised only when VEC_ALU_CTRL_FMADD_EN is defined.
module alu_field_decode
  import vec_alu_ctrl_pkg::*;
(
  input  logic [2:0] alu_op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [2:0] alu_ctrl_c,
  output logic [1:0] branch_op_c,
  output logic       sltc_c,
  output logic [1:0] op_dsp_c,
  output logic       fmadd_c,
  output logic       illegal_c
);

  always_comb begin
    alu_ctrl_c  = ALU_ADD;
    branch_op_c = BR_NONE;
    sltc_c      = 1'b0;
    op_dsp_c    = DSP_ADD;
    fmadd_c     = 1'b0;
    illegal_c   = 1'b0;
    if (!alu_op[2]) begin
      if (alu_op[1:0] == 2'b10 && funct3 == 3'b000 && funct7[5]) alu_ctrl_c = ALU_SUB;
      else if (alu_op[1])                                          alu_ctrl_c = f3_to_alu(funct3);
      else if (!alu_op[0])                                         alu_ctrl_c = ALU_ADD;
      else alu_ctrl_c = (funct3[2:1] == 2'b11) ? ALU_SLT : ALU_SUB;

      sltc_c = alu_op[1] & (funct3[2:1] == 2'b01);
      if (sltc_c) begin
        branch_op_c = BR_LT;
      end else if (alu_op[1:0] == 2'b01) begin
        if (funct3[2])             branch_op_c = funct3[0] ? BR_GE : BR_LT;
        else if (funct3 == 3'b001) branch_op_c = BR_EQ;
      end
    end else begin
      case ({funct3, funct7})
        {F3_VADD, F7_VADD}: op_dsp_c = DSP_ADD;
        {F3_VSUB, F7_VSUB}: op_dsp_c = DSP_SUB;
        {F3_VMUL, F7_VMUL}: op_dsp_c = DSP_MUL;
`ifdef VEC_ALU_CTRL_FMADD_EN
        {F3_VFMADD, F7_VFMADD}: begin
          op_dsp_c = DSP_MUL;
          fmadd_c  = 1'b1;
        end
`endif
        default: illegal_c = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/vec_alu_ctrl.sv
// Vector ALU controller: accepts one decoded request and emits its output beats.
// Define VEC_ALU_CTRL_FMADD_EN to enable two-pass vfmadd sequencing (VEC_ACC).
module vec_alu_ctrl
  import vec_alu_ctrl_pkg::*;
#(
  parameter  int unsigned LANES       = 4,
  parameter  int unsigned ISSUE_LANES = 2,
  localparam int unsigned NUM_BEATS   = (LANES + ISSUE_LANES - 1) / ISSUE_LANES,
  localparam int unsigned BEAT_W      = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        alu_op,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        alu_ctrl,
  output logic [1:0]        branch_op,
  output logic              sltc,
  output logic [1:0]        op_dsp,
  output logic [LANES-1:0]  lane_mask,
  output logic [BEAT_W-1:0] beat,
  output logic              pass,
  output logic              last,
  output logic              illegal
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

  // Lanes covered by issue beat k
  function automatic logic [LANES-1:0] beat_mask(input logic [BEAT_W-1:0] k);
    logic [LANES-1:0] m;
    int unsigned      lo;
    lo = 32'(k) * ISSUE_LANES;
    for (int unsigned i = 0; i < LANES; i++) m[i] = (i >= lo) && (i < lo + ISSUE_LANES);
    return m;
  endfunction

  state_t            state_q, state_d;
  logic              rst_done_q;
  logic              vfm_q, vfm_d;
  logic              out_valid_d, sltc_d, pass_d, last_d, illegal_d;
  logic [2:0]        alu_ctrl_d;
  logic [1:0]        branch_op_d, op_dsp_d;
  logic [LANES-1:0]  lane_mask_d;
  logic [BEAT_W-1:0] beat_d, nxt_beat_c;
  logic              fire_c, finish_c;

  logic [2:0] dec_alu_ctrl;
  logic [1:0] dec_branch_op, dec_op_dsp;
  logic       dec_sltc, dec_fmadd, dec_illegal;

  alu_field_decode u_decode (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7      (funct7),
    .alu_ctrl_c  (dec_alu_ctrl),
    .branch_op_c (dec_branch_op),
    .sltc_c      (dec_sltc),
    .op_dsp_c    (dec_op_dsp),
    .fmadd_c     (dec_fmadd),
    .illegal_c   (dec_illegal)
  );

  assign fire_c     = out_valid & out_ready;
  assign nxt_beat_c = beat + BEAT_W'(1);
  assign in_ready   = rst_done_q & ~flush & ((state_q == IDLE) | (fire_c & last));

  // Next state and next registered outputs
  always_comb begin
    state_d     = state_q;
    vfm_d       = vfm_q;
    out_valid_d = out_valid;
    alu_ctrl_d  = alu_ctrl;
    branch_op_d = branch_op;
    sltc_d      = sltc;
    op_dsp_d    = op_dsp;
    lane_mask_d = lane_mask;
    beat_d      = beat;
    pass_d      = pass;
    last_d      = last;
    illegal_d   = illegal;
    finish_c    = 1'b0;

    if (!flush) begin
      case (state_q)
        SCALAR: if (fire_c) finish_c = 1'b1;
        VEC: begin
          if (fire_c) begin
            if (last) begin
              finish_c = 1'b1;
`ifdef VEC_ALU_CTRL_FMADD_EN
            end else if (vfm_q) begin
              state_d  = VEC_ACC;
              pass_d   = 1'b1;
              op_dsp_d = DSP_ADD;
              last_d   = (beat == LAST_BEAT);
`endif
            end else begin
              beat_d      = nxt_beat_c;
              lane_mask_d = beat_mask(nxt_beat_c);
              last_d      = (nxt_beat_c == LAST_BEAT) & ~vfm_q;
            end
          end
        end
`ifdef VEC_ALU_CTRL_FMADD_EN
        VEC_ACC: begin
          if (fire_c) begin
            if (last) begin
              finish_c = 1'b1;
            end else begin
              state_d     = VEC;
              beat_d      = nxt_beat_c;
              lane_mask_d = beat_mask(nxt_beat_c);
              pass_d      = 1'b0;
              op_dsp_d    = DSP_MUL;
              last_d      = 1'b0;
            end
          end
        end
`endif
        default: ;
      endcase
    end

    if (flush || finish_c) begin
      state_d     = IDLE;
      vfm_d       = 1'b0;
      out_valid_d = 1'b0;
      alu_ctrl_d  = '0;
      branch_op_d = '0;
      sltc_d      = 1'b0;
      op_dsp_d    = '0;
      lane_mask_d = '0;
      beat_d      = '0;
      pass_d      = 1'b0;
      last_d      = 1'b0;
      illegal_d   = 1'b0;
    end

    // New request; in_ready already excludes flush
    if (in_ready && in_valid) begin
      out_valid_d = 1'b1;
      alu_ctrl_d  = '0;
      branch_op_d = '0;
      sltc_d      = 1'b0;
      op_dsp_d    = DSP_ADD;
      lane_mask_d = '0;
      beat_d      = '0;
      pass_d      = 1'b0;
      last_d      = 1'b1;
      illegal_d   = 1'b0;
      vfm_d       = 1'b0;
      if (!alu_op[2]) begin
        state_d     = SCALAR;
        alu_ctrl_d  = dec_alu_ctrl;
        branch_op_d = dec_branch_op;
        sltc_d      = dec_sltc;
      end else if (dec_illegal) begin
        state_d   = VEC;
        illegal_d = 1'b1;
      end else begin
        state_d     = VEC;
        op_dsp_d    = dec_op_dsp;
        lane_mask_d = beat_mask('0);
        last_d      = (NUM_BEATS == 1) & ~dec_fmadd;
        vfm_d       = dec_fmadd;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rst_done_q <= 1'b0;
      vfm_q      <= 1'b0;
      out_valid  <= 1'b0;
      alu_ctrl   <= '0;
      branch_op  <= '0;
      sltc       <= 1'b0;
      op_dsp     <= '0;
      lane_mask  <= '0;
      beat       <= '0;
      pass       <= 1'b0;
      last       <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rst_done_q <= 1'b1;
      vfm_q      <= vfm_d;
      out_valid  <= out_valid_d;
      alu_ctrl   <= alu_ctrl_d;
      branch_op  <= branch_op_d;
      sltc       <= sltc_d;
      op_dsp     <= op_dsp_d;
      lane_mask  <= lane_mask_d;
      beat       <= beat_d;
      pass       <= pass_d;
      last       <= last_d;
      illegal    <= illegal_d;
    end
  end

endmodule

// File: tb/tb_vec_alu_ctrl.sv
// Randomised self-checking bench for vec_alu_ctrl (LANES=5, ISSUE_LANES=2) with a
// beat-list reference model; follows VEC_ALU_CTRL_FMADD_EN when it is defined.
module tb_vec_alu_ctrl;

  localparam int LANES = 5;
  localparam int IL    = 2;
  localparam int NB    = 3;
  localparam int BW    = 2;
`ifdef VEC_ALU_CTRL_FMADD_EN
  localparam bit FMADD = 1'b1;
`else
  localparam bit FMADD = 1'b0;
`endif

  typedef struct packed {
    logic [2:0]       alu_ctrl;
    logic [1:0]       branch_op;
    logic             sltc;
    logic [1:0]       op_dsp;
    logic [LANES-1:0] lane_mask;
    logic [BW-1:0]    beat;
    logic             pass;
    logic             last;
    logic             illegal;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]       alu_op, funct3, alu_ctrl;
  logic [6:0]       funct7;
  logic [1:0]       branch_op, op_dsp;
  logic             sltc, pass, last, illegal;
  logic [LANES-1:0] lane_mask;
  logic [BW-1:0]    beat;
  beat_t            got_beat;

  beat_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    rdy_mode = 1;   // 0 random, 1 always ready, 2 never ready

  always #5 clk = ~clk;

  vec_alu_ctrl #(.LANES(LANES), .ISSUE_LANES(IL)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct3(funct3), .funct7(funct7),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_ctrl(alu_ctrl), .branch_op(branch_op), .sltc(sltc),
    .op_dsp(op_dsp), .lane_mask(lane_mask), .beat(beat),
    .pass(pass), .last(last), .illegal(illegal)
  );

  assign got_beat = '{alu_ctrl, branch_op, sltc, op_dsp, lane_mask, beat, pass, last, illegal};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected beat list for one accepted request
  task automatic model_push(input logic [2:0] op, input logic [2:0] f3, input logic [6:0] f7);
    beat_t      b;
    int         passes, lo, hi;
    logic [1:0] code;
    bit         legal;
    b = '0;
    if (!op[2]) begin
      if (op[1:0] == 2'b10 && f3 == 3'd0 && f7[5]) b.alu_ctrl = 3'd1;
      else if (op[1]) begin
        case (f3)
          3'd0: b.alu_ctrl = 3'd0; 3'd1: b.alu_ctrl = 3'd2;
          3'd2: b.alu_ctrl = 3'd1; 3'd3: b.alu_ctrl = 3'd3;
          3'd4: b.alu_ctrl = 3'd5; 3'd5: b.alu_ctrl = 3'd4;
          3'd6: b.alu_ctrl = 3'd6; default: b.alu_ctrl = 3'd7;
        endcase
      end else if (op[1:0] == 2'b00) b.alu_ctrl = 3'd0;
      else b.alu_ctrl = (f3 >= 3'd6) ? 3'd3 : 3'd1;
      b.sltc = op[1] && (f3 == 3'd2 || f3 == 3'd3);
      if (b.sltc) b.branch_op = 2'd2;
      else if (op[1:0] == 2'b01) begin
        if (f3 == 3'd4 || f3 == 3'd6)      b.branch_op = 2'd2;
        else if (f3 == 3'd5 || f3 == 3'd7) b.branch_op = 2'd3;
        else if (f3 == 3'd1)               b.branch_op = 2'd1;
      end
      b.last = 1'b1;
      exp_q.push_back(b);
      return;
    end
    passes = 1;
    legal  = 1'b1;
    code   = 2'd0;
    if (f3 == 3'd0 && f7 == 7'd0)                   code = 2'd0;
    else if (f3 == 3'd0 && f7 == 7'd4)              code = 2'd3;
    else if (f3 == 3'd1 && f7 == 7'h40)             code = 2'd1;
    else if (FMADD && f3 == 3'd3 && f7 == 7'h43)    passes = 2;
    else                                            legal = 1'b0;
    if (!legal) begin
      b.illegal = 1'b1;
      b.last    = 1'b1;
      exp_q.push_back(b);
      return;
    end
    for (int k = 0; k < NB; k++) begin
      lo = k * IL;
      hi = (lo + IL > LANES) ? LANES : lo + IL;
      for (int p = 0; p < passes; p++) begin
        b           = '0;
        b.op_dsp    = (passes == 2) ? ((p == 0) ? 2'd1 : 2'd0) : code;
        b.lane_mask = LANES'((1 << hi) - (1 << lo));
        b.beat      = BW'(k);
        b.pass      = (p == 1);
        b.last      = (k == NB - 1) && (p == passes - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  // Output-side monitor and scoreboard
  always @(negedge clk) begin
    logic exp_ir;
    if (rst_n) begin
      check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      exp_ir = !flush && ((exp_q.size() == 0) || (out_ready && exp_q[0].last));
      check("in_ready", 32'(in_ready), 32'(exp_ir));
      if (exp_q.size() != 0) begin
        check("beat_fields", 32'(got_beat), 32'(exp_q[0]));
        if (out_ready) void'(exp_q.pop_front());
      end
      if (flush) exp_q.delete();
      else if (in_valid && exp_ir) model_push(alu_op, funct3, funct7);
    end
  end

  always @(negedge rst_n) exp_q.delete();

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = ($urandom_range(0, 9) < 7);
        1:       out_ready = 1'b1;
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Present a request from posedge+1 until it is accepted
  task automatic req(input logic [2:0] op, input logic [2:0] f3, input logic [6:0] f7);
    bit acc = 1'b0;
    in_valid = 1'b1;
    alu_op   = op;
    funct3   = f3;
    funct7   = f7;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) check("req_timeout", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_fields"}, 32'(got_beat), 32'd0);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_ready"}, 32'(in_ready), 32'd0);
  endtask

  initial begin
    logic [2:0] op, f3;
    logic [6:0] f7;
    rst_n    = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    alu_op   = '0;
    funct3   = '0;
    funct7   = '0;
    #3;
    check_reset_outputs("reset");
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_ready", 32'(in_ready), 32'd1);

    // Scalar SUB
    req(3'b010, 3'b000, 7'b0100000);
    drain();
    // vsub across a partial final beat
    req(3'b100, 3'b000, 7'b0000100);
    drain();
    // vmul with three stall cycles on beat 0
    rdy_mode = 2;
    req(3'b100, 3'b001, 7'b1000000);
    repeat (3) @(posedge clk);
    #1 rdy_mode = 1;
    drain();
    // vfmadd (two passes when enabled, illegal otherwise)
    req(3'b100, 3'b011, 7'b1000011);
    drain();
    // Back-to-back requests
    req(3'b001, 3'b101, 7'd0);
    req(3'b100, 3'b000, 7'd0);
    req(3'b011, 3'b010, 7'd0);
    drain();

    // Flush during beat 1 of vadd with a competing request
    req(3'b100, 3'b000, 7'd0);
    @(posedge clk);
    #1;
    flush    = 1'b1;
    in_valid = 1'b1;
    alu_op   = 3'b010;
    funct3   = 3'b000;
    funct7   = 7'd0;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_idle", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    drain();

    // Asynchronous reset mid-sequence, then an illegal vector op
    rdy_mode = 2;
    req(3'b100, 3'b011, 7'b1000011);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clk);
    #1 rst_n = 1'b1;
    rdy_mode = 1;
    @(posedge clk);
    #1;
    check("rst_ready", 32'(in_ready), 32'd1);
    req(3'b100, 3'b000, 7'b1111111);
    drain();

    // Random traffic with random backpressure, gaps and flushes
    rdy_mode = 0;
    for (int n = 0; n < 120; n++) begin
      op = 3'($urandom_range(0, 7));
      f3 = 3'($urandom_range(0, 7));
      f7 = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'($urandom_range(0, 127));
      if (op[2]) begin
        case ($urandom_range(0, 5))
          0: begin f3 = 3'd0; f7 = 7'h00; end
          1: begin f3 = 3'd0; f7 = 7'h04; end
          2: begin f3 = 3'd1; f7 = 7'h40; end
          3: begin f3 = 3'd3; f7 = 7'h43; end
          default: ;
        endcase
      end
      case ($urandom_range(0, 9))
        0: begin
          flush = 1'b1;
          @(posedge clk);
          #1 flush = 1'b0;
        end
        1: begin
          repeat ($urandom_range(1, 4)) @(posedge clk);
          #1;
        end
        default: ;
      endcase
      req(op, f3, f7);
    end
    rdy_mode = 1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
